// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the ALU pipeline and seq_divider.
// The master issues operations; the slave (the divider) returns results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle through a
// ripple-carry trial subtractor, then a sign fix-up cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e state_q, state_d;
    logic   load, iter, fix;

    logic [WIDTH-1:0] r_q, q_q, dvsr_q, orig_q;
    logic [CntW-1:0]  cnt_q;
    logic             q_neg_q, r_neg_q, dz_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             div_by_zero_q, done_q;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // exactly its unsigned magnitude.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor : bus.divisor;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             no_borrow;

    assign shifted = {r_q, q_q[WIDTH-1]};

    // Full-adder chain: shifted + ~{0,divisor} + 1. The top stage sees an inverted
    // zero, so its carry-out collapses to a | c.
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = shifted[i] ^ ~dvsr_q[i] ^ carry;
            carry   = (shifted[i] & ~dvsr_q[i]) | (carry & (shifted[i] ^ ~dvsr_q[i]));
        end
        no_borrow = shifted[WIDTH] | carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (cnt_q == CntW'(1)) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load     = (state_q == StIdle) && bus.start;
        iter     = (state_q == StRun);
        fix      = (state_q == StFix);
        bus.busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q           <= '0;
            q_q           <= '0;
            dvsr_q        <= '0;
            orig_q        <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= fix;
            if (load) begin
                r_q     <= '0;
                q_q     <= a_mag;
                dvsr_q  <= b_mag;
                orig_q  <= bus.dividend;
                cnt_q   <= CntW'(WIDTH);
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                dz_q    <= (bus.divisor == '0);
            end
            if (iter) begin
                r_q   <= no_borrow ? diff : shifted[WIDTH-1:0];
                q_q   <= {q_q[WIDTH-2:0], no_borrow};
                cnt_q <= cnt_q - CntW'(1);
            end
            if (fix) begin
                // Divide-by-zero skips the sign fix-up entirely.
                quotient_q    <= dz_q ? '1 : (q_neg_q ? -q_q : q_q);
                remainder_q   <= dz_q ? orig_q : (r_neg_q ? -r_q : r_q);
                div_by_zero_q <= dz_q;
            end
        end
    end

    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule
